// File: rtl/rll_pkg.sv
// Shared state type, counter width and key-mask helper for the keyed RLL pipeline.
package rll_pkg;
   localparam int RLL_MAX_KW = 64;
   localparam int RLL_MAX_DW = 256;
   localparam int RLL_KI_W   = $clog2(RLL_MAX_KW);
   localparam int RLL_DI_W   = $clog2(RLL_MAX_DW);
   localparam int RLL_KEY_W  = 16;
   localparam int RLL_CNT_W  = $clog2(RLL_KEY_W + 1);

   typedef enum logic [1:0] {
      UNKEYED = 2'd0,
      DRAIN   = 2'd1,
      LOADING = 2'd2,
      ACTIVE  = 2'd3
   } rll_state_e;

   // Data bit i is gated by key bit (i mod key_w); a set mask bit marks an XNOR gate.
   function automatic logic [RLL_MAX_DW-1:0] rll_kmask(
      input logic [RLL_MAX_KW-1:0] key,
      input logic [RLL_MAX_KW-1:0] mask,
      input int                    key_w,
      input int                    data_w
   );
      logic [RLL_MAX_DW-1:0] m;
      m = {RLL_MAX_DW{1'b0}};
      for (int i = 0; i < RLL_MAX_DW; i++) begin
         if (i < data_w) begin
            m[RLL_DI_W'(i)] = key[RLL_KI_W'(i % key_w)] ^ mask[RLL_KI_W'(i % key_w)];
         end else begin
            m[RLL_DI_W'(i)] = 1'b0;
         end
      end
      return m;
   endfunction
endpackage

// File: rtl/rll_pipe_stage.sv
// One valid/data register slice; the parent decides when the slice may advance.
module rll_pipe_stage #(
   parameter int DATA_W = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              advance,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);
   logic              valid_r;
   logic [DATA_W-1:0] data_r;

   // Slice register: flush zeroizes, otherwise load when allowed to advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_W{1'b0}};
      end else if (flush) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_W{1'b0}};
      end else if (advance) begin
         valid_r <= in_valid;
         if (in_valid) begin
            data_r <= in_data;
         end
      end
   end

   assign out_valid = valid_r;
   assign out_data  = data_r;
endmodule

// File: rtl/rll_keyed_pipe.sv
// Sequential RLL lock wrapper: serially loaded key gates a valid/ready data pipeline.
module rll_keyed_pipe
   import rll_pkg::*;
#(
   parameter int               DATA_W      = 18,
   parameter int               KEY_W       = 16,
   parameter int               PIPE_STAGES = 2,
   parameter logic [KEY_W-1:0] XNOR_MASK   = 16'h50CD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_start,
   input  logic              key_clear,
   input  logic              key_in_valid,
   input  logic              key_in_bit,
   output logic              key_in_ready,
   output logic              key_loaded,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);
   localparam int CNT_W = $clog2(KEY_W + 1);

   rll_state_e        state_r;
   rll_state_e        state_nxt_s;
   logic [KEY_W-1:0]  shadow_r;
   logic [KEY_W-1:0]  key_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              loaded_r;
   logic              key_fire_s;
   logic              last_bit_s;
   logic              pipe_empty_s;
   logic [DATA_W-1:0] kmask_s;

   logic [PIPE_STAGES:0] vld_s;
   logic [PIPE_STAGES:0] rdy_s;
   logic [DATA_W-1:0]    dat_s [PIPE_STAGES+1];

   assign key_fire_s   = key_in_valid && (state_r == LOADING);
   assign last_bit_s   = key_fire_s && (cnt_r == CNT_W'(KEY_W - 1));
   assign pipe_empty_s = ~|vld_s[PIPE_STAGES:1];
   assign kmask_s      = DATA_W'(rll_kmask(RLL_MAX_KW'(key_r), RLL_MAX_KW'(XNOR_MASK),
                                           KEY_W, DATA_W));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= UNKEYED;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; key_clear overrides every other request, including load completion.
   always_comb begin
      state_nxt_s = state_r;
      if (key_clear) begin
         state_nxt_s = UNKEYED;
      end else begin
         case (state_r)
            UNKEYED: state_nxt_s = key_start    ? LOADING : UNKEYED;
            ACTIVE:  state_nxt_s = key_start    ? DRAIN   : ACTIVE;
            DRAIN:   state_nxt_s = pipe_empty_s ? LOADING : DRAIN;
            LOADING: state_nxt_s = last_bit_s   ? ACTIVE  : LOADING;
            default: state_nxt_s = UNKEYED;
         endcase
      end
   end

   // Key shift register, active key, bit counter and loaded flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_r <= {KEY_W{1'b0}};
         key_r    <= {KEY_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         loaded_r <= 1'b0;
      end else if (key_clear) begin
         shadow_r <= {KEY_W{1'b0}};
         key_r    <= {KEY_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         loaded_r <= 1'b0;
      end else if (key_fire_s) begin
         shadow_r <= {key_in_bit, shadow_r[KEY_W-1:1]};
         if (last_bit_s) begin
            key_r    <= {key_in_bit, shadow_r[KEY_W-1:1]};
            cnt_r    <= {CNT_W{1'b0}};
            loaded_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else if ((state_r == DRAIN) && pipe_empty_s) begin
         // The old key becomes unusable as soon as a reload begins.
         loaded_r <= 1'b0;
      end
   end

   // Backward ready chain: a slice may load when its own slot is free or it is moving on.
   always_comb begin
      rdy_s              = {(PIPE_STAGES + 1){1'b0}};
      rdy_s[PIPE_STAGES] = out_ready;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         rdy_s[k] = !vld_s[k+1] || rdy_s[k+1];
      end
   end

   assign vld_s[0] = in_valid && (state_r == ACTIVE);
   assign dat_s[0] = in_data ^ kmask_s;

   for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
      rll_pipe_stage #(
         .DATA_W (DATA_W)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (key_clear),
         .advance   (rdy_s[g]),
         .in_valid  (vld_s[g]),
         .in_data   (dat_s[g]),
         .out_valid (vld_s[g+1]),
         .out_data  (dat_s[g+1])
      );
   end

   assign in_ready     = (state_r == ACTIVE) && rdy_s[0];
   assign key_in_ready = (state_r == LOADING);
   assign key_loaded   = loaded_r;
   assign out_valid    = vld_s[PIPE_STAGES];
   assign out_data     = dat_s[PIPE_STAGES];
endmodule

// File: tb/tb_rll_keyed_pipe.sv
// Randomized self-checking bench for rll_keyed_pipe against a queue-based reference model.
module tb_rll_keyed_pipe;
   localparam int          DATA_W = 18;
   localparam int          KEY_W  = 16;
   localparam int          P      = 2;
   localparam logic [15:0] MASK   = 16'h50CD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_start, key_clear, key_in_valid, key_in_bit;
   logic        key_in_ready, key_loaded;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [17:0] in_data, out_data;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [17:0] q_data [$];
   int          q_time [$];
   logic [15:0] model_key = 16'h0000;
   bit          model_active = 1'b0;

   always #5 clk = ~clk;

   rll_keyed_pipe #(
      .DATA_W      (DATA_W),
      .KEY_W       (KEY_W),
      .PIPE_STAGES (P),
      .XNOR_MASK   (MASK)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_start    (key_start),
      .key_clear    (key_clear),
      .key_in_valid (key_in_valid),
      .key_in_bit   (key_in_bit),
      .key_in_ready (key_in_ready),
      .key_loaded   (key_loaded),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready)
   );

   // Gate mask = (key ^ mask) repeated across the word.
   function automatic logic [17:0] model_mask(input logic [15:0] key);
      logic [15:0] x;
      x = key ^ MASK;
      return 18'({x, x});
   endfunction

   // Called mid-cycle: records handshakes into the model, then moves to 1 ns after the edge.
   task automatic tick();
      logic in_fire, out_fire;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (key_clear) begin
         q_data.delete();
         q_time.delete();
      end else begin
         if (out_fire && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_time.pop_front());
         end
         if (in_fire) begin
            q_data.push_back(in_data ^ model_mask(model_key));
            q_time.push_back(cyc);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic load_key(input logic [15:0] key, input int cut_at);
      bit ok;
      key_start = 1'b1;
      @(negedge clk);
      tick();
      key_start    = 1'b0;
      model_active = 1'b0;
      ok = 1'b0;
      for (int w = 0; w < 40; w++) begin
         @(negedge clk);
         if (key_in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL load_wait_ready: key_in_ready=%b required 1 within 40 cycles", key_in_ready);
      end
      checks++;
      if (key_loaded !== 1'b0) begin
         failures++;
         $display("FAIL loading_key_loaded: got %b required 0", key_loaded);
      end
      tick();
      for (int b = 0; b < KEY_W; b++) begin
         if ($urandom_range(0, 1) == 1) begin
            key_in_valid = 1'b0;
            @(negedge clk);
            tick();
         end
         key_in_valid = 1'b1;
         key_in_bit   = key[b];
         key_clear    = (b == cut_at);
         @(negedge clk);
         checks++;
         if (key_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL key_in_ready bit %0d: got %b required 1", b, key_in_ready);
         end
         checks++;
         if (key_loaded !== 1'b0) begin
            failures++;
            $display("FAIL early_key_loaded bit %0d: got %b required 0", b, key_loaded);
         end
         tick();
         key_in_valid = 1'b0;
         if (b == cut_at) begin
            key_clear    = 1'b0;
            model_active = 1'b0;
            @(negedge clk);
            checks++;
            if ({key_loaded, in_ready, key_in_ready} !== 3'b000) begin
               failures++;
               $display("FAIL clear_midload: loaded/in_ready/key_in_ready=%b required 000",
                        {key_loaded, in_ready, key_in_ready});
            end
            tick();
            return;
         end
      end
      @(negedge clk);
      checks++;
      if ({key_loaded, key_in_ready} !== 2'b10) begin
         failures++;
         $display("FAIL load_done: loaded/key_in_ready=%b required 10", {key_loaded, key_in_ready});
      end
      model_key    = key;
      model_active = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, key_in_ready, key_loaded} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: ov/ir/kir/kl=%b required 0000",
                  {out_valid, in_ready, key_in_ready, key_loaded});
      end
      checks++;
      if (out_data !== 18'h0) begin
         failures++;
         $display("FAIL reset_out_data: got %h required 0", out_data);
      end
      tick();
   endtask

   // One word through an empty pipe: checks key effect and exact latency.
   task automatic test_single(input logic [15:0] key, input logic [17:0] din,
                              input logic [17:0] dout);
      load_key(key, -1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = din;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_in_ready: got %b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_latency_early: out_valid=%b required 0", out_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== dout) begin
         failures++;
         $display("FAIL single_word: out_valid=%b out_data=%h required 1/%h",
                  out_valid, out_data, dout);
      end
      tick();
   endtask

   // mode 0: back-to-back with out_ready=1; mode 1: random valid, out_ready 1,0,0,...
   task automatic test_stream(input int n, input int mode);
      int          sent, got;
      bit          prev_stall, pending;
      logic [17:0] prev_data;
      logic        exp_ir, exp_ov;
      sent = 0; got = 0; prev_stall = 1'b0; pending = 1'b0; prev_data = 18'h0;
      for (int c = 0; c < 400; c++) begin
         if (sent == n && q_data.size() == 0) break;
         out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
         if (!pending) begin
            if (sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) begin
               in_valid = 1'b1;
               in_data  = 18'($urandom);
               pending  = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         exp_ir = model_active && (out_ready || q_data.size() < P);
         exp_ov = (q_data.size() > 0) && (cyc - q_time[0] >= P);
         checks++;
         if (in_ready !== exp_ir) begin
            failures++;
            $display("FAIL stream_in_ready c%0d: got %b required %b", c, in_ready, exp_ir);
         end
         checks++;
         if (out_valid !== exp_ov) begin
            failures++;
            $display("FAIL stream_out_valid c%0d: got %b required %b", c, out_valid, exp_ov);
         end
         if (exp_ov) begin
            checks++;
            if (out_data !== q_data[0]) begin
               failures++;
               $display("FAIL stream_data c%0d: got %h required %h", c, out_data, q_data[0]);
            end
         end
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               failures++;
               $display("FAIL stall_stable c%0d: got %b/%h required 1/%h",
                        c, out_valid, out_data, prev_data);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (in_valid && in_ready) begin
            sent++;
            pending = 1'b0;
         end
         if (out_valid && out_ready) got++;
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (got != n || q_data.size() != 0) begin
         failures++;
         $display("FAIL stream_count: got %0d words (%0d pending) required %0d", got,
                  q_data.size(), n);
      end
      tick();
   endtask

   task automatic test_reload(input logic [15:0] new_key);
      bit ok;
      out_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_valid = 1'b1;
         in_data  = 18'($urandom);
         @(negedge clk);
         tick();
      end
      key_start = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reload_full_in_ready: got %b required 0", in_ready);
      end
      tick();
      key_start    = 1'b0;
      model_active = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, key_in_ready, key_loaded, out_valid} !== 4'b0011) begin
            failures++;
            $display("FAIL drain_hold c%0d: ir/kir/kl/ov=%b required 0011", c,
                     {in_ready, key_in_ready, key_loaded, out_valid});
         end
         tick();
      end
      out_ready = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_in_ready c%0d: got %b required 0", c, in_ready);
         end
         if (key_in_ready) begin
            ok = 1'b1;
            break;
         end
         if (out_valid) begin
            checks++;
            if (q_data.size() == 0 || out_data !== q_data[0]) begin
               failures++;
               $display("FAIL drain_old_key c%0d: got %h required %h", c, out_data, q_data[0]);
            end
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!ok || q_data.size() != 0 || key_loaded !== 1'b0) begin
         failures++;
         $display("FAIL drain_done: ready=%b left=%0d key_loaded=%b required 1/0/0", ok,
                  q_data.size(), key_loaded);
      end
      tick();
      load_key(new_key, -1);
      test_stream(6, 0);
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 18'($urandom);
      @(negedge clk);
      tick();
      in_data   = 18'($urandom);
      key_clear = 1'b1;
      @(negedge clk);
      tick();
      key_clear    = 1'b0;
      in_valid     = 1'b0;
      model_active = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, key_in_ready, key_loaded} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_active c%0d: ov/ir/kir/kl=%b required 0000", c,
                     {out_valid, in_ready, key_in_ready, key_loaded});
         end
         tick();
      end
      load_key(16'h50CD, 9);
      load_key(16'h50CD, -1);
      test_stream(5, 0);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_valid = 1'b1;
         in_data  = 18'($urandom);
         @(negedge clk);
         tick();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, key_in_ready, key_loaded} !== 4'b0000 || out_data !== 18'h0) begin
         failures++;
         $display("FAIL async_reset: ov/ir/kir/kl=%b out_data=%h required 0000/0",
                  {out_valid, in_ready, key_in_ready, key_loaded}, out_data);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      q_data.delete();
      q_time.delete();
      model_active = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, key_loaded, key_in_ready} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset: ov/kl/kir=%b required 000", {out_valid, key_loaded, key_in_ready});
      end
      tick();
      load_key(16'h50CD, -1);
      test_stream(4, 1);
   endtask

   initial begin
      rst_n = 1'b0; key_start = 1'b0; key_clear = 1'b0; key_in_valid = 1'b0;
      key_in_bit = 1'b0; in_valid = 1'b0; in_data = 18'h0; out_ready = 1'b0;
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_single(16'h50CD, 18'h2AB3C, 18'h2AB3C);
      test_stream(8, 0);
      test_single(16'h50CC, 18'h2AB3C, 18'h3AB3D);
      test_stream(6, 1);
      test_reload(16'h1234);
      test_stream(6, 1);
      test_clear();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
